// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow line-memory port between an I-cache and a D-cache.
// One transaction at a time: the winner's request is latched and held until mem_ready.
//
// state  | meaning
// IDLE   | no transaction; sample both requesters and pick a winner
// BUSY_I | I-cache request latched onto the memory port, waiting for mem_ready
// BUSY_D | D-cache request latched onto the memory port, waiting for mem_ready
// DONE_I | memI_ready pulse; memI_rdata holds the returned line
// DONE_D | memD_ready pulse; memD_rdata holds the returned line
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              memI_read,
    input  logic              memI_write,
    input  logic [ADDR_W-1:0] memI_addr,
    input  logic [DATA_W-1:0] memI_wdata,
    output logic [DATA_W-1:0] memI_rdata,
    output logic              memI_ready,
    input  logic              memD_read,
    input  logic              memD_write,
    input  logic [ADDR_W-1:0] memD_addr,
    input  logic [DATA_W-1:0] memD_wdata,
    output logic [DATA_W-1:0] memD_rdata,
    output logic              memD_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_i,
    output logic              grant_d
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   req_i, req_d, pick_d;

    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] memI_rdata_q, memD_rdata_q;

    always_comb begin
        req_i  = memI_read | memI_write;
        req_d  = memD_read | memD_write;
        // On a tie the requester that was not served last wins.
        pick_d = req_d & (~req_i | (last_grant == GRANT_I));
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        unique case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_nxt = pick_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_nxt      = DONE_I;
                    last_grant_nxt = GRANT_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_nxt      = DONE_D;
                    last_grant_nxt = GRANT_D;
                end
            end
            DONE_I:  state_nxt = IDLE;
            DONE_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and read-data capture; write wins when both strobes are high.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            memI_rdata_q <= '0;
            memD_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        mem_write_q <= memD_write;
                        mem_read_q  <= memD_read & ~memD_write;
                        mem_addr_q  <= memD_addr;
                        mem_wdata_q <= memD_wdata;
                    end else if (req_i) begin
                        mem_write_q <= memI_write;
                        mem_read_q  <= memI_read & ~memI_write;
                        mem_addr_q  <= memI_addr;
                        mem_wdata_q <= memI_wdata;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        memI_rdata_q <= mem_rdata;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        memD_rdata_q <= mem_rdata;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign memI_rdata = memI_rdata_q;
    assign memD_rdata = memD_rdata_q;
    assign memI_ready = (state == DONE_I);
    assign memD_ready = (state == DONE_D);
    assign grant_i    = (state == BUSY_I) || (state == DONE_I);
    assign grant_d    = (state == BUSY_D) || (state == DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for round-robin, write-back/refill, mid-transaction reset and read+write.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [ADDR_W-1:0] D_ADDR  = 28'h0000010;
    localparam logic [ADDR_W-1:0] I_ADDR  = 28'h0000100;
    localparam logic [DATA_W-1:0] D_WDATA = {4{32'hDDDD_0001}};
    localparam logic [DATA_W-1:0] I_WDATA = {4{32'h1111_0002}};
    localparam logic [DATA_W-1:0] WB_DATA = {4{32'h5555_AAAA}};
    localparam logic [DATA_W-1:0] Z0      = '0;
    localparam logic [DATA_W-1:0] R1      = {4{32'h0123_4567}};
    localparam logic [DATA_W-1:0] R2      = {4{32'hDEAD_BEEF}};
    localparam logic [DATA_W-1:0] R3      = {4{32'h89AB_CDEF}};
    localparam logic [DATA_W-1:0] RA5     = {16{8'hA5}};

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              memI_read, memI_write, memD_read, memD_write;
    logic [ADDR_W-1:0] memI_addr, memD_addr, mem_addr;
    logic [DATA_W-1:0] memI_wdata, memD_wdata, memI_rdata, memD_rdata;
    logic              memI_ready, memD_ready;
    logic              mem_read, mem_write, mem_ready, grant_i, grant_d;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .memI_read(memI_read), .memI_write(memI_write), .memI_addr(memI_addr),
        .memI_wdata(memI_wdata), .memI_rdata(memI_rdata), .memI_ready(memI_ready),
        .memD_read(memD_read), .memD_write(memD_write), .memD_addr(memD_addr),
        .memD_wdata(memD_wdata), .memD_rdata(memD_rdata), .memD_ready(memD_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              i_rd, i_wr, d_rd, d_wr, m_rdy;
        logic [DATA_W-1:0] m_rdata;
        logic              e_mr, e_mw, e_gi, e_gd, e_ri, e_rd;
        logic [DATA_W-1:0] e_i_rdata, e_d_rdata;
        logic              chk_a;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memI_read = 0; memI_write = 0; memD_read = 0; memD_write = 0;
        mem_ready = 0; mem_rdata = R2;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, " mem_read"}, mem_read, 1'b0);
        chk1({tag, " mem_write"}, mem_write, 1'b0);
        chkw({tag, " mem_addr"}, DATA_W'(mem_addr), Z0);
        chkw({tag, " mem_wdata"}, mem_wdata, Z0);
        chk1({tag, " memI_ready"}, memI_ready, 1'b0);
        chk1({tag, " memD_ready"}, memD_ready, 1'b0);
        chkw({tag, " memI_rdata"}, memI_rdata, Z0);
        chkw({tag, " memD_rdata"}, memD_rdata, Z0);
        chk1({tag, " grant_i"}, grant_i, 1'b0);
        chk1({tag, " grant_d"}, grant_d, 1'b0);
    endtask

    task automatic do_reset();
        proc_reset = 1;
        idle_inputs();
        step();
        step();
        proc_reset = 0;
    endtask

    initial begin
        // Simultaneous I read / D write after reset (D first), then a lone D read.
        vecs[0]  = '{H,L,L,H,L,R2,  L,H,L,H,L,L, Z0,Z0,  H,D_ADDR,D_WDATA};
        vecs[1]  = '{H,L,L,H,L,R2,  L,H,L,H,L,L, Z0,Z0,  L,D_ADDR,Z0};
        vecs[2]  = '{H,L,L,H,H,R1,  L,L,L,H,L,H, Z0,R1,  L,D_ADDR,Z0};
        vecs[3]  = '{H,L,L,L,H,R2,  L,L,L,L,L,L, Z0,R1,  L,D_ADDR,Z0};
        vecs[4]  = '{H,L,L,L,L,R2,  H,L,H,L,L,L, Z0,R1,  H,I_ADDR,I_WDATA};
        vecs[5]  = '{H,L,L,L,H,R3,  L,L,H,L,H,L, R3,R1,  L,D_ADDR,Z0};
        vecs[6]  = '{L,L,L,L,H,R2,  L,L,L,L,L,L, R3,R1,  L,D_ADDR,Z0};
        vecs[7]  = '{L,L,H,L,H,R2,  H,L,L,H,L,L, R3,R1,  H,D_ADDR,D_WDATA};
        vecs[8]  = '{L,L,H,L,L,R2,  H,L,L,H,L,L, R3,R1,  L,D_ADDR,Z0};
        vecs[9]  = '{L,L,H,L,L,R2,  H,L,L,H,L,L, R3,R1,  L,D_ADDR,Z0};
        vecs[10] = '{L,L,H,L,L,R2,  H,L,L,H,L,L, R3,R1,  L,D_ADDR,Z0};
        vecs[11] = '{L,L,H,L,H,RA5, L,L,L,H,L,H, R3,RA5, L,D_ADDR,Z0};
        vecs[12] = '{L,L,L,L,L,R2,  L,L,L,L,L,L, R3,RA5, L,D_ADDR,Z0};

        memI_addr = I_ADDR; memI_wdata = I_WDATA;
        memD_addr = D_ADDR; memD_wdata = D_WDATA;
        do_reset();
        check_reset("reset");

        for (int k = 0; k < NV; k++) begin
            memI_read  = vecs[k].i_rd;
            memI_write = vecs[k].i_wr;
            memD_read  = vecs[k].d_rd;
            memD_write = vecs[k].d_wr;
            mem_ready  = vecs[k].m_rdy;
            mem_rdata  = vecs[k].m_rdata;
            step();
            chk1($sformatf("v%0d mem_read", k), mem_read, vecs[k].e_mr);
            chk1($sformatf("v%0d mem_write", k), mem_write, vecs[k].e_mw);
            chk1($sformatf("v%0d grant_i", k), grant_i, vecs[k].e_gi);
            chk1($sformatf("v%0d grant_d", k), grant_d, vecs[k].e_gd);
            chk1($sformatf("v%0d memI_ready", k), memI_ready, vecs[k].e_ri);
            chk1($sformatf("v%0d memD_ready", k), memD_ready, vecs[k].e_rd);
            chkw($sformatf("v%0d memI_rdata", k), memI_rdata, vecs[k].e_i_rdata);
            chkw($sformatf("v%0d memD_rdata", k), memD_rdata, vecs[k].e_d_rdata);
            if (vecs[k].chk_a) begin
                chkw($sformatf("v%0d mem_addr", k), DATA_W'(mem_addr), DATA_W'(vecs[k].e_addr));
                chkw($sformatf("v%0d mem_wdata", k), mem_wdata, vecs[k].e_wdata);
            end
        end

        // Round-robin with both requesters continuously pending.
        begin
            logic order[8];
            int   n_grant = 0;
            int   overlap = 0;
            logic pgi = 0, pgd = 0;
            do_reset();
            memI_read = 1; memD_read = 1;
            for (int c = 0; c < 40; c++) begin
                step();
                if (grant_i && grant_d) overlap++;
                if (grant_d && !pgd && n_grant < 8) begin order[n_grant] = 1'b1; n_grant++; end
                if (grant_i && !pgi && n_grant < 8) begin order[n_grant] = 1'b0; n_grant++; end
                pgi = grant_i; pgd = grant_d;
                mem_ready = mem_read | mem_write;
            end
            chk1("rr at least 4 grants", n_grant >= 4, 1'b1);
            chkw("rr grant overlap", DATA_W'(overlap), Z0);
            for (int g = 0; g < 4; g++) begin
                if (g < n_grant)
                    chk1($sformatf("rr grant %0d is D", g), order[g], (g % 2 == 0));
            end
        end

        // D write-back then refill read, separated by an IDLE cycle.
        do_reset();
        memD_write = 1; memD_addr = 28'h0000001; memD_wdata = WB_DATA;
        step();
        chk1("wb mem_write", mem_write, 1'b1);
        chk1("wb mem_read", mem_read, 1'b0);
        chkw("wb mem_addr", DATA_W'(mem_addr), DATA_W'(28'h0000001));
        chkw("wb mem_wdata", mem_wdata, WB_DATA);
        mem_ready = 1;
        step();
        chk1("wb memD_ready", memD_ready, 1'b1);
        memD_write = 0; memD_read = 1; memD_addr = 28'h0000002; mem_ready = 0;
        step();
        chk1("gap grant_d", grant_d, 1'b0);
        chk1("gap mem_read", mem_read, 1'b0);
        chk1("gap memD_ready", memD_ready, 1'b0);
        step();
        chk1("refill mem_read", mem_read, 1'b1);
        chk1("refill mem_write", mem_write, 1'b0);
        chkw("refill mem_addr", DATA_W'(mem_addr), DATA_W'(28'h0000002));
        mem_ready = 1; mem_rdata = R3;
        step();
        chk1("refill memD_ready", memD_ready, 1'b1);
        chkw("refill memD_rdata", memD_rdata, R3);
        memD_read = 0; mem_ready = 0;
        step();

        // Reset during BUSY_I, then a stray mem_ready.
        memI_read = 1; memI_write = 0; memI_addr = I_ADDR;
        step();
        chk1("busy_i grant_i", grant_i, 1'b1);
        proc_reset = 1;
        step();
        proc_reset = 0; memI_read = 0; mem_ready = 1; mem_rdata = R1;
        check_reset("mid-reset");
        step();
        mem_ready = 0;
        check_reset("stray ready");

        // I with read and write both high: write wins.
        memI_read = 1; memI_write = 1; memI_wdata = I_WDATA;
        step();
        chk1("rw mem_write", mem_write, 1'b1);
        chk1("rw mem_read", mem_read, 1'b0);
        chk1("rw grant_i", grant_i, 1'b1);
        chkw("rw mem_wdata", mem_wdata, I_WDATA);
        mem_ready = 1;
        step();
        chk1("rw memI_ready", memI_ready, 1'b1);
        idle_inputs();
        step();
        chk1("rw back idle", grant_i | grant_d, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
